bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares the single synchronous system memory port (ROM/RAM, fixed read latency) between the cornet CPU and the chroni video fetcher. Each requester uses a level req / one-cycle ack handshake. Video has priority to protect scanline timing; a bounded-run counter guarantees CPU progress. The block sits between both requesters and the memory instances, all on sys_clk.

## Interface
- ADDR_W, 16, address width of both requesters and memory port
- DATA_W, 8, data width
- MEM_LATENCY, 1, cycles from mem_addr valid to mem_rd_data valid (1..4)
- MAX_VID_RUN, 4, max consecutive video grants while CPU is pending (1..15)

- sys_clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; qualifies cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wr_data  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rd_data  out  DATA_W  read data, valid while cpu_ack=1, held until next CPU read completes
- vid_req  in  1  video read request, level, held until vid_ack
- vid_addr  in  ADDR_W  video address
- vid_ack  out  1  one-cycle completion pulse
- vid_rd_data  out  DATA_W  read data, valid while vid_ack=1
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, MEM_LATENCY after mem_addr
- bus_owner  out  2  0 none, 1 CPU, 2 video

## Operation
- FSM: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests and pick a winner. Latch the winner's addr, we and wr_data, set bus_owner, go to ISSUE. Nothing pending: stay, bus_owner=0.
- Priority:
  - Video wins a simultaneous request unless run_cnt == MAX_VID_RUN; then CPU wins.
  - Lone requester always wins.
- run_cnt (4 bit):
  - +1 on each video grant made while cpu_req=1.
  - Cleared on any CPU grant, or on a video grant while cpu_req=0.
  - Saturates at MAX_VID_RUN.
- ISSUE: drive mem_addr from the latch.
  - Write: mem_we=1 for this cycle only, next state DONE.
  - Read: next state WAIT, latency counter loaded with MEM_LATENCY-1.
- WAIT: decrement the counter. At zero, capture mem_rd_data into the owner's rd_data register, then go to DONE.
- DONE: pulse the owner's ack, clear bus_owner, return to IDLE.
- Requester protocol violations:
  - req dropped before ack: the transaction still completes and ack still pulses.
  - req changed while granted: ignored, because the address was latched at grant.
- The other requester's request is held pending, never lost.
- Video writes are not supported; the video port has no we.
- Reset values:
  - state=IDLE, run_cnt=0, bus_owner=0, cpu_ack=vid_ack=0, mem_we=0.
  - mem_addr=0, mem_wr_data=0, cpu_rd_data=vid_rd_data=0.
- Reset mid-transaction: abort immediately; no ack is issued and no mem_we appears after the reset edge.

## Timing
- Cycle 0 (IDLE) samples the request.
- Read: mem_addr valid from cycle 1; ack in cycle 2+MEM_LATENCY. With default latency, ack is in cycle 3.
- Write: mem_we in cycle 1, ack in cycle 2.
- Ack cycle is DONE, next cycle is IDLE. A requester deasserting req the cycle after ack is not re-granted.
- A req still high in IDLE is a new request.
- Throughput:
  - Back-to-back reads: one per 3+MEM_LATENCY cycles.
  - Writes: one per 3 cycles.
- mem_addr holds its last value outside ISSUE/WAIT. mem_we=0 outside ISSUE.
- All outputs are registered; there is no combinational req→ack path.

## Structure
- Package bus_pkg:
  - state enum
  - owner codes OWNER_NONE/OWNER_CPU/OWNER_VID
  - address and data width defaults, shared with system and chroni
- Sub-module bus_fairness_counter holds run_cnt:
  - inputs: grant_vid, grant_cpu, cpu_pending
  - output: force_cpu
- FSM, latches and datapath stay in bus_arbiter.

## Test plan
- CPU read alone, addr 0x0123, mem returns 0xA5: mem_addr=0x0123 in cycle 1, cpu_ack with cpu_rd_data=0xA5 in cycle 3, bus_owner 1→0.
- CPU write 0x5A to 0x2000: mem_we=1 with mem_addr=0x2000, mem_wr_data=0x5A exactly in cycle 1, cpu_ack in cycle 2, vid_ack never.
- Both requesters continuously asserted, MAX_VID_RUN=4: grant order VVVVC repeating, and CPU is never starved beyond 4 video grants.
- Simultaneous request with cpu_req=0 during prior video runs: run_cnt stays 0 and video wins every tie.
- reset_n low during WAIT of a video read: no vid_ack, all outputs at reset values next cycle, fresh CPU read afterwards completes in 3 cycles.
- MEM_LATENCY=3: ack in cycle 5, data captured from the third cycle after mem_addr; CPU drops req early → ack still pulses once.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared state, owner codes and bus width defaults for the system memory port
package bus_pkg;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWNER_NONE = 2'd0, OWNER_CPU = 2'd1, OWNER_VID = 2'd2} owner_t;
endpackage

// File: rtl/bus_fairness_counter.sv
// bus_fairness_counter: counts consecutive video grants taken while the CPU waits
module bus_fairness_counter #(
  parameter int MAX_VID_RUN = 4
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic grant_vid,
  input  logic grant_cpu,
  input  logic cpu_pending,
  output logic force_cpu
);
  logic [3:0] run_cnt;
  always_ff @(posedge sys_clk)
    if (!reset_n || grant_cpu || (grant_vid && !cpu_pending)) run_cnt <= '0;
    else if (grant_vid && run_cnt != 4'(MAX_VID_RUN)) run_cnt <= run_cnt + 4'd1;
  assign force_cpu = run_cnt == 4'(MAX_VID_RUN);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the system memory port between the CPU and the video fetcher
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_VID_RUN = 4
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rd_data,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [1:0]        bus_owner
);
  state_t     state;
  owner_t     owner;
  logic [1:0] lat_cnt;
  logic       force_cpu, grant_cpu, grant_vid;
  assign grant_cpu = state == IDLE && cpu_req && (!vid_req || force_cpu);
  assign grant_vid = state == IDLE && vid_req && !grant_cpu;
  assign bus_owner = owner;
  bus_fairness_counter #(.MAX_VID_RUN(MAX_VID_RUN)) u_fair (
    .sys_clk(sys_clk), .reset_n(reset_n), .grant_vid(grant_vid),
    .grant_cpu(grant_cpu), .cpu_pending(cpu_req), .force_cpu(force_cpu)
  );
  // mem_addr/mem_we double as the grant-time latch, so they are valid from ISSUE onward
  always_ff @(posedge sys_clk)
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= OWNER_NONE;
      lat_cnt     <= '0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      cpu_rd_data <= '0;
      vid_rd_data <= '0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: if (grant_cpu || grant_vid) begin
          state    <= ISSUE;
          owner    <= grant_cpu ? OWNER_CPU : OWNER_VID;
          mem_addr <= grant_cpu ? cpu_addr : vid_addr;
          mem_we   <= grant_cpu && cpu_we;
          if (grant_cpu) mem_wr_data <= cpu_wr_data;
        end
        ISSUE: begin
          state   <= mem_we ? DONE : WAIT;
          cpu_ack <= mem_we;
          lat_cnt <= 2'(MEM_LATENCY - 1);
        end
        WAIT: if (lat_cnt == 2'd0) begin
          state   <= DONE;
          cpu_ack <= owner == OWNER_CPU;
          vid_ack <= owner == OWNER_VID;
          if (owner == OWNER_CPU) cpu_rd_data <= mem_rd_data;
          else vid_rd_data <= mem_rd_data;
        end else lat_cnt <= lat_cnt - 2'd1;
        DONE: begin
          state <= IDLE;
          owner <= OWNER_NONE;
        end
      endcase
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors, fairness sequences and a randomized scoreboard run
module tb_bus_arbiter;
  localparam int LAT = 1;
  localparam int MAXRUN = 4;
  logic sys_clk = 1'b0, reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;
  logic cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
  logic [15:0] cpu_addr = '0, vid_addr = '0;
  logic [7:0] cpu_wr_data = '0;
  logic cpu_ack, vid_ack, mem_we, cpu_ack3, vid_ack3, mem_we3;
  logic [7:0] cpu_rd_data, vid_rd_data, mem_wr_data, mem_rd_data;
  logic [7:0] cpu_rd_data3, vid_rd_data3, mem_wr_data3, mem_rd_data3;
  logic [15:0] mem_addr, mem_addr3;
  logic [1:0] bus_owner, bus_owner3;
  bus_arbiter dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_ack(cpu_ack), .cpu_rd_data(cpu_rd_data),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rd_data(vid_rd_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .bus_owner(bus_owner)
  );
  bus_arbiter #(.MEM_LATENCY(3)) dut3 (
    .sys_clk(sys_clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_ack(cpu_ack3), .cpu_rd_data(cpu_rd_data3),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack3), .vid_rd_data(vid_rd_data3),
    .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wr_data(mem_wr_data3), .mem_rd_data(mem_rd_data3),
    .bus_owner(bus_owner3)
  );
  // synchronous memories with 1 and 3 cycles of read latency, preloadable from the bench
  logic [7:0] mem1 [65536];
  logic [7:0] mem3 [65536];
  logic [7:0] p1;
  logic [7:0] p3 [3];
  logic pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  always @(posedge sys_clk) begin
    if (pre_en) mem1[pre_addr] <= pre_data;
    else if (mem_we) mem1[mem_addr] <= mem_wr_data;
    if (pre_en) mem3[pre_addr] <= pre_data;
    else if (mem_we3) mem3[mem_addr3] <= mem_wr_data3;
    p1 <= mem1[mem_addr];
    p3[0] <= mem3[mem_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rd_data = p1;
  assign mem_rd_data3 = p3[2];
  logic [7:0] ref_mem [256];
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_en = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge sys_clk);
    pre_en = 1'b0;
  endtask
  task automatic cpu_txn(input logic we, input logic [15:0] a, input logic [7:0] d,
                         output int ack_cyc, output int ack_cnt, output logic [7:0] rd,
                         output logic [15:0] a1, output logic we1, output logic [7:0] wd1,
                         output logic [1:0] own1, output int we_cnt, output int vack_cnt,
                         output logic [1:0] own_after);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wr_data = d;
    ack_cyc = -1; ack_cnt = 0; rd = '0; we_cnt = 0; vack_cnt = 0; own_after = 2'd3;
    a1 = '0; we1 = 1'b0; wd1 = '0; own1 = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge sys_clk);
      if (n == 1) begin
        a1 = mem_addr; we1 = mem_we; wd1 = mem_wr_data; own1 = bus_owner;
        cpu_addr = ~a; cpu_wr_data = ~d;
      end
      if (ack_cyc > 0 && n == ack_cyc + 1) own_after = bus_owner;
      we_cnt += int'(mem_we);
      vack_cnt += int'(vid_ack);
      if (cpu_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin ack_cyc = n; rd = cpu_rd_data; end
        cpu_req = 1'b0;
      end
    end
  endtask
  task automatic vid_txn(input logic [15:0] a, output int ack_cyc, output logic [7:0] rd, output int cack_cnt);
    vid_req = 1'b1; vid_addr = a; ack_cyc = -1; rd = '0; cack_cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge sys_clk);
      if (n == 1) vid_addr = ~a;
      cack_cnt += int'(cpu_ack);
      if (vid_ack) begin
        if (ack_cyc < 0) begin ack_cyc = n; rd = vid_rd_data; end
        vid_req = 1'b0;
      end
    end
  endtask
  task automatic both_run(input int n, output logic [15:0] seq, output int got);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123; vid_req = 1'b1; vid_addr = 16'h2000;
    got = 0; seq = '0;
    for (int c = 0; c < 10 * n && got < n; c++) begin
      @(negedge sys_clk);
      if (cpu_ack) begin
        chk("tie_cpu_data", 32'(cpu_rd_data), 32'h A5);
        seq[got[3:0]] = 1'b1;
        got++;
      end
      if (vid_ack) begin
        chk("tie_vid_data", 32'(vid_rd_data), 32'h5A);
        got++;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (8) @(negedge sys_clk);
  endtask
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          ack;
    logic [7:0]  rd;
  } vec_t;
  vec_t tbl [6];
  int ack_cyc, ack_cnt, we_cnt, vack_cnt, cack_cnt, got;
  logic [7:0] rd, wd1;
  logic [15:0] a1, seq;
  logic we1;
  logic [1:0] own1, own_after;
  int free_at, vid_run, exp_c, exp_v;
  logic [7:0] last_crd, exp_vd;
  logic c_busy, v_busy, c_gr, v_gr;
  initial begin
    tbl[0] = '{1'b0, 16'h0123, 8'h00, 3, 8'hA5};
    tbl[1] = '{1'b1, 16'h2000, 8'h5A, 2, 8'hA5};
    tbl[2] = '{1'b0, 16'h2000, 8'h00, 3, 8'h5A};
    tbl[3] = '{1'b0, 16'hFFFF, 8'h00, 3, 8'h3C};
    tbl[4] = '{1'b1, 16'h0000, 8'hC3, 2, 8'h3C};
    tbl[5] = '{1'b0, 16'h0000, 8'h00, 3, 8'hC3};
    @(negedge sys_clk);
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      preload(16'h4000 | 16'(i), ref_mem[i]);
    end
    preload(16'h0123, 8'hA5);
    preload(16'hFFFF, 8'h3C);
    preload(16'h0000, 8'h11);
    preload(16'h0456, 8'h77);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_vid_ack", 32'(vid_ack), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wr_data", 32'(mem_wr_data), 0);
    chk("rst_cpu_rd_data", 32'(cpu_rd_data), 0);
    chk("rst_vid_rd_data", 32'(vid_rd_data), 0);
    chk("rst_bus_owner", 32'(bus_owner), 0);
    reset_n = 1'b1;
    @(negedge sys_clk);
    for (int i = 0; i < 6; i++) begin
      cpu_txn(tbl[i].we, tbl[i].addr, tbl[i].wd, ack_cyc, ack_cnt, rd, a1, we1, wd1, own1, we_cnt, vack_cnt, own_after);
      chk($sformatf("vec%0d_ack_cycle", i), 32'(ack_cyc), 32'(tbl[i].ack));
      chk($sformatf("vec%0d_ack_count", i), 32'(ack_cnt), 1);
      chk($sformatf("vec%0d_rd_data", i), 32'(rd), 32'(tbl[i].rd));
      chk($sformatf("vec%0d_mem_addr_c1", i), 32'(a1), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_mem_we_c1", i), 32'(we1), 32'(tbl[i].we));
      chk($sformatf("vec%0d_we_pulses", i), 32'(we_cnt), 32'(tbl[i].we));
      if (tbl[i].we) chk($sformatf("vec%0d_mem_wr_data_c1", i), 32'(wd1), 32'(tbl[i].wd));
      chk($sformatf("vec%0d_owner_c1", i), 32'(own1), 1);
      chk($sformatf("vec%0d_owner_after", i), 32'(own_after), 0);
      chk($sformatf("vec%0d_no_vid_ack", i), 32'(vack_cnt), 0);
    end
    // video runs alone must not build up a run against an idle CPU
    for (int i = 0; i < 5; i++) begin
      vid_txn(16'h2000, ack_cyc, rd, cack_cnt);
      chk("vid_alone_ack_cycle", 32'(ack_cyc), 3);
      chk("vid_alone_data", 32'(rd), 32'h5A);
      chk("vid_alone_no_cpu_ack", 32'(cack_cnt), 0);
    end
    both_run(10, seq, got);
    chk("tie_grant_count", 32'(got), 10);
    chk("tie_grant_order", 32'(seq), 32'b10_0001_0000);
    // reset while a video read is waiting on memory
    vid_req = 1'b1; vid_addr = 16'h0123;
    repeat (2) @(negedge sys_clk);
    chk("rst_mid_owner_before", 32'(bus_owner), 2);
    reset_n = 1'b0; vid_req = 1'b0;
    @(negedge sys_clk);
    chk("rst_mid_vid_ack", 32'(vid_ack), 0);
    chk("rst_mid_mem_we", 32'(mem_we), 0);
    chk("rst_mid_mem_addr", 32'(mem_addr), 0);
    chk("rst_mid_owner", 32'(bus_owner), 0);
    chk("rst_mid_vid_rd_data", 32'(vid_rd_data), 0);
    chk("rst_mid_cpu_rd_data", 32'(cpu_rd_data), 0);
    reset_n = 1'b1;
    cack_cnt = 0;
    repeat (3) begin
      @(negedge sys_clk);
      cack_cnt += int'(vid_ack) + int'(mem_we);
    end
    chk("rst_mid_no_late_ack_or_we", 32'(cack_cnt), 0);
    cpu_txn(1'b0, 16'h0123, 8'h00, ack_cyc, ack_cnt, rd, a1, we1, wd1, own1, we_cnt, vack_cnt, own_after);
    chk("post_rst_ack_cycle", 32'(ack_cyc), 3);
    chk("post_rst_data", 32'(rd), 32'hA5);
    // latency-3 instance with the CPU dropping req right after grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0456;
    ack_cyc = -1; ack_cnt = 0; rd = '0; a1 = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge sys_clk);
      if (n == 1) begin cpu_req = 1'b0; a1 = mem_addr3; end
      if (cpu_ack3) begin
        ack_cnt++;
        if (ack_cyc < 0) begin ack_cyc = n; rd = cpu_rd_data3; end
      end
    end
    chk("lat3_mem_addr_c1", 32'(a1), 32'h0456);
    chk("lat3_ack_cycle", 32'(ack_cyc), 5);
    chk("lat3_ack_count", 32'(ack_cnt), 1);
    chk("lat3_data", 32'(rd), 32'h77);
    // randomized run against a transaction-level scoreboard
    reset_n = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    free_at = 0; vid_run = 0; exp_c = -1; exp_v = -1; last_crd = '0; exp_vd = '0;
    c_busy = 1'b0; v_busy = 1'b0; c_gr = 1'b0; v_gr = 1'b0;
    for (int t = 0; t < 800; t++) begin
      @(negedge sys_clk);
      if (t == exp_c) begin
        chk("rnd_cpu_ack", 32'(cpu_ack), 1);
        chk("rnd_cpu_data", 32'(cpu_rd_data), 32'(last_crd));
      end else chk("rnd_cpu_no_ack", 32'(cpu_ack), 0);
      if (t == exp_v) begin
        chk("rnd_vid_ack", 32'(vid_ack), 1);
        chk("rnd_vid_data", 32'(vid_rd_data), 32'(exp_vd));
      end else chk("rnd_vid_no_ack", 32'(vid_ack), 0);
      if (cpu_ack) begin
        cpu_req = 1'b0; c_busy = 1'b0; c_gr = 1'b0;
      end else if (c_gr) begin
        cpu_addr = 16'($urandom); cpu_wr_data = 8'($urandom); cpu_we = 1'($urandom_range(1));
      end else if (!c_busy && $urandom_range(2) == 0) begin
        c_busy = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
        cpu_addr = 16'h4000 | 16'($urandom_range(255)); cpu_wr_data = 8'($urandom);
      end
      if (vid_ack) begin
        vid_req = 1'b0; v_busy = 1'b0; v_gr = 1'b0;
      end else if (v_gr) vid_addr = 16'($urandom);
      else if (!v_busy && $urandom_range(1) == 0) begin
        v_busy = 1'b1; vid_req = 1'b1; vid_addr = 16'h4000 | 16'($urandom_range(255));
      end
      if (t >= free_at && (cpu_req || vid_req)) begin
        if (cpu_req && (!vid_req || vid_run == MAXRUN)) begin
          vid_run = 0; c_gr = 1'b1;
          if (cpu_we) begin
            ref_mem[cpu_addr[7:0]] = cpu_wr_data;
            exp_c = t + 2;
          end else begin
            last_crd = ref_mem[cpu_addr[7:0]];
            exp_c = t + 2 + LAT;
          end
          free_at = exp_c + 1;
        end else begin
          vid_run = cpu_req ? (vid_run < MAXRUN ? vid_run + 1 : MAXRUN) : 0;
          v_gr = 1'b1;
          exp_vd = ref_mem[vid_addr[7:0]];
          exp_v = t + 2 + LAT;
          free_at = exp_v + 1;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
